ddr5_cmd_sequencer: RTL and testbench

Synthesizable single-bank-at-a-time DDR5 command sequencer using a closed-page policy. It sits between the 16-entry request scheduler queue and the DIMM command bus. It accepts one decoded request at a time over a valid/ready handshake. It then issues ACT0, ACT1, RD0/RD1 or WR0/WR1, then PRE, spacing them to meet tRCD, tRAS, tRTP, tCWD+BURST+tWR, tRP and tRC. Commands go out only on DIMM-clock ticks, which occur every second CPU cycle.

---
 rtl/ddr5_pkg.sv | 44 ++++
 rtl/ddr5_timing_counter.sv | 26 ++
 rtl/ddr5_cmd_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_ddr5_cmd_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr5_pkg.sv
// Shared types and default timing for the DDR5 command sequencer:
// command codes, request encoding and the request record.
package ddr5_pkg;

  typedef enum logic [2:0] {
    ACT0 = 3'd0,
    ACT1 = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    WR0  = 3'd4,
    WR1  = 3'd5,
    PRE  = 3'd6
  } cmd_t;

  localparam logic [1:0] OPN_READ   = 2'd0;
  localparam logic [1:0] OPN_WRITE  = 2'd1;
  localparam logic [1:0] OPN_IFETCH = 2'd2;
  localparam logic [1:0] OPN_RSVD   = 2'd3;

  // Default timing, all in CPU cycles.
  localparam int T_RC_DEF  = 115;
  localparam int T_RAS_DEF = 76;
  localparam int T_RP_DEF  = 39;
  localparam int T_RCD_DEF = 39;
  localparam int T_RTP_DEF = 18;
  localparam int T_CWD_DEF = 38;
  localparam int T_WR_DEF  = 30;
  localparam int BURST_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef struct packed {
    logic [1:0]  opn;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
  } req_t;

  // Only opn 1 writes; fetch and the reserved code behave as reads.
  function automatic logic is_write(input logic [1:0] opn);
    return opn == OPN_WRITE;
  endfunction

endpackage

// File: rtl/ddr5_timing_counter.sv
// Saturating up-counter with synchronous clear; resets to all ones so a
// freshly reset sequencer sees every timing window as already elapsed.
module ddr5_timing_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;

  // cnt_next is the value held next cycle when no clear is applied.
  always_comb cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= CNT_MAX;
    else if (clr) cnt <= '0;
    else          cnt <= cnt_next;
  end

endmodule

// File: rtl/ddr5_cmd_sequencer.sv
// Closed-page DDR5 command sequencer: ACT0/ACT1, RD or WR pair, then PRE,
// issued on DIMM ticks. Define CMD_TRACE_EN to print every issued command.
module ddr5_cmd_sequencer
  import ddr5_pkg::*;
#(
  parameter int T_RC  = T_RC_DEF,
  parameter int T_RAS = T_RAS_DEF,
  parameter int T_RP  = T_RP_DEF,
  parameter int T_RCD = T_RCD_DEF,
  parameter int T_RTP = T_RTP_DEF,
  parameter int T_CWD = T_CWD_DEF,
  parameter int T_WR  = T_WR_DEF,
  parameter int BURST = BURST_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_opn,
  input  logic [2:0]  req_bg,
  input  logic [1:0]  req_bank,
  input  logic [15:0] req_row,
  input  logic [9:0]  req_col,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_addr,
  output logic        busy,
  output logic        done
);

  localparam int CNT_MAX_I = (2 ** CNT_W) - 1;
  localparam logic [CNT_W:0] TH_RC  = (CNT_W+1)'(T_RC);
  localparam logic [CNT_W:0] TH_RAS = (CNT_W+1)'(T_RAS);
  localparam logic [CNT_W:0] TH_RP  = (CNT_W+1)'(T_RP);
  localparam logic [CNT_W:0] TH_RCD = (CNT_W+1)'(T_RCD);
  localparam logic [CNT_W:0] TH_RTP = (CNT_W+1)'(T_RTP);
  localparam logic [CNT_W:0] TH_WCOL = (CNT_W+1)'(T_CWD) + (CNT_W+1)'(BURST)
                                     + (CNT_W+1)'(T_WR);

  if (T_RC > CNT_MAX_I || T_RAS > CNT_MAX_I || T_RP > CNT_MAX_I ||
      T_RCD > CNT_MAX_I || T_RTP > CNT_MAX_I ||
      int'(TH_WCOL) > CNT_MAX_I) begin : g_bad_timing
    $error("ddr5_cmd_sequencer: timing threshold exceeds counter range");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACT0, ST_ACT1, ST_COL0, ST_COL1, ST_PRE
  } st_t;

  st_t              state, state_nxt;
  req_t             req_q, req_in, req_cur;
  logic             phase;
  logic             transfer;
  logic             issue;
  cmd_t             issue_code;
  logic [15:0]      issue_addr;
  logic             act_gate, col_gate, pre_gate;
  logic [CNT_W-1:0] act_nx, col_nx, pre_nx;

  ddr5_timing_counter #(.CNT_W(CNT_W)) u_act_cnt (
    .clk(clk), .rst_n(rst_n), .clr(issue && issue_code == ACT0), .cnt_next(act_nx)
  );
  ddr5_timing_counter #(.CNT_W(CNT_W)) u_col_cnt (
    .clk(clk), .rst_n(rst_n),
    .clr(issue && (issue_code == RD0 || issue_code == WR0)), .cnt_next(col_nx)
  );
  ddr5_timing_counter #(.CNT_W(CNT_W)) u_pre_cnt (
    .clk(clk), .rst_n(rst_n), .clr(issue && issue_code == PRE), .cnt_next(pre_nx)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign transfer  = req_valid && req_ready;
  assign req_in    = '{opn: req_opn, bg: req_bg, bank: req_bank, row: req_row, col: req_col};
  assign req_cur   = (state == ST_IDLE) ? req_in : req_q;

  // Gates look at counter values of the next cycle, because the command
  // register loaded now is what appears on the bus then.
  assign act_gate = ({1'b0, pre_nx} >= TH_RP) && ({1'b0, act_nx} >= TH_RC);
  assign col_gate = ({1'b0, act_nx} >= TH_RCD);
  assign pre_gate = ({1'b0, act_nx} >= TH_RAS) &&
                    (is_write(req_cur.opn) ? ({1'b0, col_nx} >= TH_WCOL)
                                           : ({1'b0, col_nx} >= TH_RTP));

  // Issue decisions are taken when phase is 1 so the command lands on a
  // tick; a state advances at the end of the cycle its command is on the bus.
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_code = ACT0;
    issue_addr = '0;
    unique case (state)
      ST_IDLE: if (transfer) begin
        state_nxt = ST_ACT0;
        if (phase && act_gate) begin
          issue      = 1'b1;
          issue_code = ACT0;
          issue_addr = req_cur.row;
        end
      end
      ST_ACT0: begin
        if (cmd_valid) state_nxt = ST_ACT1;
        else if (phase && act_gate) begin
          issue      = 1'b1;
          issue_code = ACT0;
          issue_addr = req_cur.row;
        end
      end
      ST_ACT1: begin
        if (cmd_valid) state_nxt = ST_COL0;
        else if (phase) begin
          issue      = 1'b1;
          issue_code = ACT1;
          issue_addr = req_cur.row;
        end
      end
      ST_COL0: begin
        if (cmd_valid) state_nxt = ST_COL1;
        else if (phase && col_gate) begin
          issue      = 1'b1;
          issue_code = is_write(req_cur.opn) ? WR0 : RD0;
          issue_addr = {6'b0, req_cur.col};
        end
      end
      ST_COL1: begin
        if (cmd_valid) state_nxt = ST_PRE;
        else if (phase) begin
          issue      = 1'b1;
          issue_code = is_write(req_cur.opn) ? WR1 : RD1;
          issue_addr = {6'b0, req_cur.col};
        end
      end
      ST_PRE: begin
        if (cmd_valid) state_nxt = ST_IDLE;
        else if (phase && pre_gate) begin
          issue      = 1'b1;
          issue_code = PRE;
          issue_addr = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase     <= 1'b0;
      req_q     <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_bg    <= '0;
      cmd_bank  <= '0;
      cmd_addr  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= ~phase;
      cmd_valid <= issue;
      done      <= issue && issue_code == PRE;
      if (transfer) req_q <= req_in;
      if (issue) begin
        cmd_code <= issue_code;
        cmd_bg   <= req_cur.bg;
        cmd_bank <= req_cur.bank;
        cmd_addr <= issue_addr;
      end
    end
  end

`ifdef CMD_TRACE_EN
  logic [31:0] trace_cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trace_cyc <= '0;
    else        trace_cyc <= trace_cyc + 32'd1;
  end

  always @(posedge clk) begin
    if (rst_n && cmd_valid)
      $display("At time %0d %s %0d %0d %0h", trace_cyc, cmd_t'(cmd_code).name(),
               cmd_bg, cmd_bank, cmd_addr);
  end
`else
`endif

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Directed bench for ddr5_cmd_sequencer: vector table of single requests plus
// hand-written back-to-back, mid-operation reset and busy-toggle sequences.
module tb_ddr5_cmd_sequencer;

  localparam logic [2:0] C_ACT0 = 3'd0;
  localparam logic [2:0] C_ACT1 = 3'd1;
  localparam logic [2:0] C_RD0  = 3'd2;
  localparam logic [2:0] C_WR0  = 3'd4;
  localparam logic [2:0] C_PRE  = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_opn = '0;
  logic [2:0]  req_bg = '0;
  logic [1:0]  req_bank = '0;
  logic [15:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_addr;
  logic        busy;
  logic        done;

  ddr5_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opn(req_opn), .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row),
    .req_col(req_col), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bg(cmd_bg),
    .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .busy(busy), .done(done)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / log ----------------
  int         log_cyc[$];
  logic [2:0] log_code[$];
  logic [15:0] log_addr[$];
  logic [4:0] log_bgbk[$];
  logic       busy_h[256];
  logic       ready_h[256];
  logic       done_h[256];

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) begin
        log_cyc.push_back(cyc);
        log_code.push_back(cmd_code);
        log_addr.push_back(cmd_addr);
        log_bgbk.push_back({cmd_bg, cmd_bank});
      end
      if (cyc < 256) begin
        busy_h[cyc]  = busy;
        ready_h[cyc] = req_ready;
        done_h[cyc]  = done;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cmd(input string tag, input int idx, input int exp_c,
                           input logic [2:0] code, input logic [15:0] addr,
                           input logic [4:0] bgbk);
    if (idx < log_cyc.size()) begin
      check($sformatf("%s_cmd%0d_cycle", tag, idx), log_cyc[idx], exp_c);
      check($sformatf("%s_cmd%0d_code", tag, idx), {29'b0, log_code[idx]}, {29'b0, code});
      check($sformatf("%s_cmd%0d_addr", tag, idx), {16'b0, log_addr[idx]}, {16'b0, addr});
      check($sformatf("%s_cmd%0d_bgbank", tag, idx), {27'b0, log_bgbk[idx]}, {27'b0, bgbk});
    end else begin
      check($sformatf("%s_cmd%0d_present", tag, idx), 32'd0, 32'd1);
    end
  endtask

  task automatic clear_logs();
    log_cyc.delete(); log_code.delete(); log_addr.delete(); log_bgbk.delete();
    for (int i = 0; i < 256; i++) begin
      busy_h[i] = 1'bx; ready_h[i] = 1'bx; done_h[i] = 1'bx;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic hold_reset();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Release reset with a request already valid, so transfer is at cycle 0.
  task automatic release_with_req(input logic [1:0] opn, input logic [2:0] bg,
                                  input logic [1:0] bank, input logic [15:0] row,
                                  input logic [9:0] col, input logic hold);
    clear_logs();
    req_opn = opn; req_bg = bg; req_bank = bank; req_row = row; req_col = col;
    req_valid = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic run_to(input int c);
    int guard = 0;
    while (cyc < c && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  opn;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
    int          exp_act0;
    int          exp_col0;
    int          exp_pre;
    logic [2:0]  exp_col_code;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int   ndone;
    int   nready;
    vec_t v;

    vecs[0] = '{2'd0, 3'd3, 2'd2, 16'h1234, 10'h055, 2, 42, 78,  C_RD0};
    vecs[1] = '{2'd1, 3'd5, 2'd1, 16'hABCD, 10'h200, 2, 42, 118, C_WR0};
    vecs[2] = '{2'd2, 3'd7, 2'd3, 16'hFFFF, 10'h3FF, 2, 42, 78,  C_RD0};
    vecs[3] = '{2'd3, 3'd0, 2'd0, 16'h0001, 10'h001, 2, 42, 78,  C_RD0};

    // Reset state.
    hold_reset();
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    check("reset_cmd_code", {29'b0, cmd_code}, 32'd0);
    check("reset_cmd_bgbank", {27'b0, cmd_bg, cmd_bank}, 32'd0);
    check("reset_cmd_addr", {16'b0, cmd_addr}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);

    // Single-request vectors.
    for (int i = 0; i < 4; i++) begin
      string tag;
      v   = vecs[i];
      tag = $sformatf("vec%0d", i);
      hold_reset();
      release_with_req(v.opn, v.bg, v.bank, v.row, v.col, 1'b0);
      run_to(v.exp_pre + 20);
      check({tag, "_ncmds"}, log_cyc.size(), 32'd5);
      check_cmd(tag, 0, v.exp_act0, C_ACT0, v.row, {v.bg, v.bank});
      check_cmd(tag, 1, v.exp_act0 + 2, C_ACT1, v.row, {v.bg, v.bank});
      check_cmd(tag, 2, v.exp_col0, v.exp_col_code, {6'b0, v.col}, {v.bg, v.bank});
      check_cmd(tag, 3, v.exp_col0 + 2, v.exp_col_code + 3'd1, {6'b0, v.col}, {v.bg, v.bank});
      check_cmd(tag, 4, v.exp_pre, C_PRE, 16'h0000, {v.bg, v.bank});
      ndone = 0;
      for (int c = 0; c < 256; c++) if (done_h[c] === 1'b1) ndone++;
      check({tag, "_done_count"}, ndone, 32'd1);
      check({tag, "_done_at_pre"}, {31'b0, done_h[v.exp_pre]}, 32'd1);
      check({tag, "_busy_after_xfer"}, {31'b0, busy_h[1]}, 32'd1);
      check({tag, "_busy_at_pre"}, {31'b0, busy_h[v.exp_pre]}, 32'd1);
      check({tag, "_busy_after_pre"}, {31'b0, busy_h[v.exp_pre + 1]}, 32'd0);
      check({tag, "_ready_after_pre"}, {31'b0, ready_h[v.exp_pre + 1]}, 32'd1);
    end

    // Back-to-back reads with req_valid held: second transfer at 79.
    hold_reset();
    release_with_req(2'd0, 3'd1, 2'd3, 16'h0BEE, 10'h012, 1'b1);
    run_to(80);
    req_valid = 1'b0;
    run_to(230);
    check("b2b_ncmds", log_cyc.size(), 32'd10);
    check_cmd("b2b", 4, 78, C_PRE, 16'h0000, {3'd1, 2'd3});
    check("b2b_ready_79", {31'b0, ready_h[79]}, 32'd1);
    check("b2b_busy_80", {31'b0, busy_h[80]}, 32'd1);
    check_cmd("b2b", 5, 118, C_ACT0, 16'h0BEE, {3'd1, 2'd3});
    check_cmd("b2b", 6, 120, C_ACT1, 16'h0BEE, {3'd1, 2'd3});
    check_cmd("b2b", 7, 158, C_RD0, 16'h0012, {3'd1, 2'd3});
    check_cmd("b2b", 9, 194, C_PRE, 16'h0000, {3'd1, 2'd3});

    // Reset during a read after RD1: no PRE, outputs cleared at once.
    hold_reset();
    release_with_req(2'd0, 3'd2, 2'd1, 16'h4444, 10'h044, 1'b0);
    run_to(50);
    check("midrst_ncmds_before", log_cyc.size(), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    check("midrst_cmd_code", {29'b0, cmd_code}, 32'd0);
    check("midrst_cmd_addr", {16'b0, cmd_addr}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    release_with_req(2'd1, 3'd6, 2'd2, 16'h0F0F, 10'h3FF, 1'b0);
    run_to(140);
    check("midrst_ncmds_after", log_cyc.size(), 32'd5);
    check_cmd("midrst", 0, 2, C_ACT0, 16'h0F0F, {3'd6, 2'd2});
    check_cmd("midrst", 2, 42, C_WR0, 16'h03FF, {3'd6, 2'd2});
    check_cmd("midrst", 4, 118, C_PRE, 16'h0000, {3'd6, 2'd2});

    // req_valid toggling while busy must not latch a second request.
    hold_reset();
    release_with_req(2'd0, 3'd2, 2'd1, 16'h00AA, 10'h3FF, 1'b0);
    req_row = 16'h5555; req_col = 10'h000; req_opn = 2'd1;
    while (cyc < 70) begin
      req_valid = cyc[0];
      @(negedge clk);
    end
    req_valid = 1'b0;
    run_to(100);
    nready = 0;
    for (int c = 1; c < 79; c++) if (ready_h[c] !== 1'b0) nready++;
    check("toggle_ready_while_busy", nready, 32'd0);
    check("toggle_ncmds", log_cyc.size(), 32'd5);
    check_cmd("toggle", 0, 2, C_ACT0, 16'h00AA, {3'd2, 2'd1});
    check_cmd("toggle", 2, 42, C_RD0, 16'h03FF, {3'd2, 2'd1});
    check_cmd("toggle", 4, 78, C_PRE, 16'h0000, {3'd2, 2'd1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
